fm_phase_diff: RTL and testbench

- Phase differentiator of the FM demodulator. Sits directly upstream of the 128-sample moving averager and feeds it.
- Takes wrapped phase samples from the CORDIC/atan stage and outputs the sample-to-sample phase difference, i.e. instantaneous frequency.
- Handles wrap at ±pi by modular arithmetic, applies a power-of-two gain with saturation, and suppresses impulsive click glitches.

---
 rtl/fm_phase_diff_if.sv | 39 +++
 rtl/fm_phase_diff.sv | 154 +++++++++++++++
 tb/tb_fm_phase_diff.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fm_phase_diff_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fm_phase_diff_if                                                |
// | Brief    : Sample stream bundle between the phase source, the phase        |
// |            differentiator and the moving averager.                         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fm_phase_diff_if #(
    parameter int WIDTH = 16
);
    logic                    start_i;
    logic                    valid_i;
    logic signed [WIDTH-1:0] phase_i;
    logic signed [WIDTH-1:0] data_o;
    logic                    valid_o;
    logic                    glitch_o;
`ifdef FM_PHASE_DIFF_GLITCH_CNT_EN
    logic [15:0]             glitch_cnt_o;

    modport master (
        output start_i, valid_i, phase_i,
        input  data_o, valid_o, glitch_o, glitch_cnt_o
    );
    modport slave (
        input  start_i, valid_i, phase_i,
        output data_o, valid_o, glitch_o, glitch_cnt_o
    );
`else
    modport master (
        output start_i, valid_i, phase_i,
        input  data_o, valid_o, glitch_o
    );
    modport slave (
        input  start_i, valid_i, phase_i,
        output data_o, valid_o, glitch_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/fm_phase_diff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fm_phase_diff                                                   |
// | Brief    : FM phase differentiator: wrapped phase in, gained, saturated,   |
// |            glitch-suppressed frequency out. Optional glitch counter under  |
// |            macro FM_PHASE_DIFF_GLITCH_CNT_EN.                              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fm_phase_diff #(
    parameter int WIDTH      = 16,
    parameter int GAIN_SHIFT = 0,
    parameter int LIMIT      = 16384
) (
    input  logic            clk,
    input  logic            rst,
    fm_phase_diff_if.slave  bus
);
    localparam int                      c_SW        = WIDTH + GAIN_SHIFT;
    localparam logic signed [WIDTH-1:0] c_SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]          c_LIMIT     = (WIDTH+1)'(LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_prime;
    logic                    w_accept;

    logic signed [WIDTH-1:0] r_phase_prev;
    logic signed [WIDTH-1:0] r_diff;
    logic                    r_s1_valid;
    logic signed [WIDTH-1:0] r_last_out;
    logic signed [WIDTH-1:0] r_data;
    logic                    r_valid_o;
    logic                    r_glitch;
`ifdef FM_PHASE_DIFF_GLITCH_CNT_EN
    logic [15:0]             r_glitch_cnt;
`endif

    logic signed [WIDTH:0]   w_diff_ext;
    logic        [WIDTH:0]   w_mag;
    logic                    w_is_glitch;
    logic signed [c_SW-1:0]  w_wide;
    logic signed [WIDTH-1:0] w_scaled;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_prime  = 1'b0;
        w_accept = 1'b0;
        if (!bus.start_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_PRIME;
                S_PRIME: begin
                    if (bus.valid_i) begin
                        w_prime = 1'b1;
                        w_next  = S_RUN;
                    end
                end
                S_RUN:   w_accept = bus.valid_i;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Magnitude is one bit wider so the most negative difference is representable.
    always_comb begin
        w_diff_ext  = (WIDTH+1)'(r_diff);
        w_mag       = w_diff_ext[WIDTH] ? unsigned'(-w_diff_ext) : unsigned'(w_diff_ext);
        w_is_glitch = (w_mag > c_LIMIT);
        w_wide      = c_SW'(r_diff) <<< GAIN_SHIFT;
        if (w_wide > c_SW'(c_SAT_MAX)) begin
            w_scaled = c_SAT_MAX;
        end else if (w_wide < c_SW'(c_SAT_MIN)) begin
            w_scaled = c_SAT_MIN;
        end else begin
            w_scaled = w_wide[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase_prev <= '0;
            r_diff       <= '0;
            r_s1_valid   <= 1'b0;
            r_last_out   <= '0;
            r_data       <= '0;
            r_valid_o    <= 1'b0;
            r_glitch     <= 1'b0;
`ifdef FM_PHASE_DIFF_GLITCH_CNT_EN
            r_glitch_cnt <= '0;
`endif
        end else if (!bus.start_i) begin
            // Flush in-flight samples; data_o deliberately keeps its last value.
            r_phase_prev <= '0;
            r_s1_valid   <= 1'b0;
            r_last_out   <= '0;
            r_valid_o    <= 1'b0;
            r_glitch     <= 1'b0;
`ifdef FM_PHASE_DIFF_GLITCH_CNT_EN
            r_glitch_cnt <= '0;
`endif
        end else begin
            r_s1_valid <= w_accept;
            if (w_prime) begin
                r_phase_prev <= bus.phase_i;
            end
            if (w_accept) begin
                r_diff       <= bus.phase_i - r_phase_prev;
                r_phase_prev <= bus.phase_i;
            end

            r_valid_o <= r_s1_valid;
            r_glitch  <= 1'b0;
            if (r_s1_valid) begin
                if (w_is_glitch) begin
                    r_data   <= r_last_out;
                    r_glitch <= 1'b1;
`ifdef FM_PHASE_DIFF_GLITCH_CNT_EN
                    if (r_glitch_cnt != 16'hFFFF) begin
                        r_glitch_cnt <= r_glitch_cnt + 16'd1;
                    end
`endif
                end else begin
                    r_data     <= w_scaled;
                    r_last_out <= w_scaled;
                end
            end
        end
    end

    assign bus.data_o   = r_data;
    assign bus.valid_o  = r_valid_o;
    assign bus.glitch_o = r_glitch;
`ifdef FM_PHASE_DIFF_GLITCH_CNT_EN
    assign bus.glitch_cnt_o = r_glitch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fm_phase_diff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fm_phase_diff                                                |
// | Brief    : Directed bench for fm_phase_diff, unity-gain and x4-gain copies |
// |            driven from one shared stimulus stream.                         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fm_phase_diff;
    localparam int WIDTH = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start;
    logic                    valid;
    logic signed [WIDTH-1:0] phase;
    int                      n_checks = 0;
    int                      n_errors = 0;

    always #5 clk = ~clk;

    fm_phase_diff_if #(.WIDTH(WIDTH)) bus_a ();
    fm_phase_diff_if #(.WIDTH(WIDTH)) bus_b ();

    assign bus_a.start_i = start;
    assign bus_a.valid_i = valid;
    assign bus_a.phase_i = phase;
    assign bus_b.start_i = start;
    assign bus_b.valid_i = valid;
    assign bus_b.phase_i = phase;

    fm_phase_diff #(.WIDTH(WIDTH), .GAIN_SHIFT(0), .LIMIT(16384)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fm_phase_diff #(.WIDTH(WIDTH), .GAIN_SHIFT(2), .LIMIT(16384)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle 1 ns past the rising edge.
    task automatic step(input logic s, input logic v, input int p);
        start = s;
        valid = v;
        phase = WIDTH'(p);
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
    endtask

    initial begin
        start = 1'b0;
        valid = 1'b0;
        phase = '0;
        #12;
        check("rst_data",   bus_a.data_o,   0);
        check("rst_valid",  bus_a.valid_o,  0);
        check("rst_glitch", bus_a.glitch_o, 0);
        rst = 1'b1;

        // Basic difference
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 100);
        check("basic_prime_v", bus_a.valid_o, 0);
        step(1'b1, 1'b1, 300);
        check("basic_lat_v",   bus_a.valid_o, 0);
        step(1'b1, 1'b1, 250);
        check("basic1_v",      bus_a.valid_o, 1);
        check("basic1_d",      bus_a.data_o,  200);
        step(1'b1, 1'b0, 0);
        check("basic2_v",      bus_a.valid_o, 1);
        check("basic2_d",      bus_a.data_o,  -50);
        step(1'b1, 1'b0, 0);
        check("basic_idle_v",  bus_a.valid_o, 0);
        check("basic_hold_d",  bus_a.data_o,  -50);

        // Wrap at +-pi
        restart();
        step(1'b1, 1'b1, 32700);
        step(1'b1, 1'b1, -32700);
        step(1'b1, 1'b1, 32700);
        check("wrap_pos_d",  bus_a.data_o,   136);
        check("wrap_pos_g",  bus_a.glitch_o, 0);
        check("wrap_pos_b",  bus_b.data_o,   544);
        step(1'b1, 1'b0, 0);
        check("wrap_neg_d",  bus_a.data_o,   -136);
        check("wrap_neg_g",  bus_a.glitch_o, 0);

        // Gain and saturation
        restart();
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1000);
        step(1'b1, 1'b1, 11000);
        check("gain_b",      bus_b.data_o, 4000);
        check("gain_a",      bus_a.data_o, 1000);
        step(1'b1, 1'b1, 1000);
        check("sat_pos_b",   bus_b.data_o, 32767);
        check("sat_pos_a",   bus_a.data_o, 10000);
        step(1'b1, 1'b0, 0);
        check("sat_neg_b",   bus_b.data_o, -32768);

        // Glitch hold and limit boundary
        restart();
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 500);
        step(1'b1, 1'b1, 21000);
        check("gl_pre_d",    bus_a.data_o,   500);
        check("gl_pre_g",    bus_a.glitch_o, 0);
        step(1'b1, 1'b1, -28152);
        check("gl_hold_v",   bus_a.valid_o,  1);
        check("gl_hold_d",   bus_a.data_o,   500);
        check("gl_hold_g",   bus_a.glitch_o, 1);
`ifdef FM_PHASE_DIFF_GLITCH_CNT_EN
        check("gl_cnt1",     bus_a.glitch_cnt_o, 1);
`endif
        step(1'b1, 1'b1, 4616);
        check("lim_eq_d",    bus_a.data_o,   16384);
        check("lim_eq_g",    bus_a.glitch_o, 0);
        check("lim_eq_b",    bus_b.data_o,   32767);
        step(1'b1, 1'b0, 0);
        check("lim_min_d",   bus_a.data_o,   16384);
        check("lim_min_g",   bus_a.glitch_o, 1);
`ifdef FM_PHASE_DIFF_GLITCH_CNT_EN
        check("gl_cnt2",     bus_a.glitch_cnt_o, 2);
`endif

        // start_i gating on a +10 ramp
        restart();
        step(1'b1, 1'b1, 0);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 10 * i);
        check("ramp_v",      bus_a.valid_o, 1);
        check("ramp_d",      bus_a.data_o,  10);
        step(1'b0, 1'b1, 40);
        check("drop_v",      bus_a.valid_o, 0);
        check("drop_keep_d", bus_a.data_o,  10);
`ifdef FM_PHASE_DIFF_GLITCH_CNT_EN
        check("drop_cnt",    bus_a.glitch_cnt_o, 0);
`endif
        step(1'b1, 1'b1, 50);
        check("regate_v0",   bus_a.valid_o, 0);
        step(1'b1, 1'b1, 60);
        check("regate_v1",   bus_a.valid_o, 0);
        step(1'b1, 1'b1, 70);
        check("regate_v2",   bus_a.valid_o, 0);
        step(1'b1, 1'b1, 80);
        check("regate_v3",   bus_a.valid_o, 1);
        check("regate_d",    bus_a.data_o,  10);

        // Asynchronous reset mid-stream
        step(1'b1, 1'b1, 90);
        check("pre_rst_d",   bus_a.data_o,  10);
        rst = 1'b0;
        #2;
        check("arst_d",      bus_a.data_o,  0);
        check("arst_v",      bus_a.valid_o, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b1, 100);
        check("post_rst_v0", bus_a.valid_o, 0);
        step(1'b1, 1'b1, 110);
        check("post_rst_v1", bus_a.valid_o, 0);
        step(1'b1, 1'b1, 120);
        check("post_rst_v2", bus_a.valid_o, 0);
        step(1'b1, 1'b1, 130);
        check("post_rst_v3", bus_a.valid_o, 1);
        check("post_rst_d",  bus_a.data_o,  10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
